// File: rtl/change_pkg.sv
// Shared types and coin denominations for the change dispenser.
// Amounts are in farthings; coin_value maps a coin to its worth.
package change_pkg;

  typedef enum logic [2:0] {IDLE, SELECT, PULSE, GAP, DONE, FAULT} state_t;
  typedef enum logic [1:0] {NONE, PENNY, HAP, FARTH} coin_t;

  localparam int PENNY_F = 4;
  localparam int HAP_F   = 2;
  localparam int FARTH_F = 1;

  function automatic int coin_value(input coin_t c);
    case (c)
      PENNY:   return PENNY_F;
      HAP:     return HAP_F;
      FARTH:   return FARTH_F;
      default: return 0;
    endcase
  endfunction

endpackage

// File: rtl/pulse_timer.sv
// Loadable down-counter shared by the eject-pulse and inter-coin gap timing.
// zero is high once the loaded count has run out; load takes priority.
module pulse_timer #(
  parameter int W = 3
) (
  input  logic         clk50m,
  input  logic         res,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         zero
);

  logic [W-1:0] r_count;

  always_ff @(posedge clk50m or negedge res) begin
    if (!res) begin
      r_count <= '0;
    end else if (load) begin
      r_count <= load_val;
    end else if (r_count != '0) begin
      r_count <= r_count - W'(1);
    end
  end

  assign zero = (r_count == '0);

endmodule

// File: rtl/change_dispenser.sv
// Pays owed change one coin at a time, largest available coin first,
// driving each hopper solenoid for a fixed pulse followed by a fixed gap.
module change_dispenser
  import change_pkg::*;
#(
  parameter int AMT_W     = 4,
  parameter int PULSE_CYC = 5,
  parameter int GAP_CYC   = 3
) (
  input  logic             clk50m,
  input  logic             res,
  input  logic             req,
  input  logic [AMT_W-1:0] amount,
  input  logic             penny_empty,
  input  logic             hap_empty,
  input  logic             farth_empty,
  output logic             eject_penny,
  output logic             eject_hap,
  output logic             eject_farth,
  output logic             busy,
  output logic             done,
  output logic             fault,
  output logic [AMT_W-1:0] remaining
);

  localparam int MAX_CYC = (PULSE_CYC > GAP_CYC) ? PULSE_CYC : GAP_CYC;
  localparam int CNT_W   = $clog2(MAX_CYC + 1);

  state_t           r_state;
  coin_t            r_coin;
  logic [AMT_W-1:0] r_remaining;
  logic             r_busy;
  logic             r_done;
  logic             r_fault;
  logic             r_eject_penny;
  logic             r_eject_hap;
  logic             r_eject_farth;

  coin_t            w_coin;
  logic             w_tmr_load;
  logic [CNT_W-1:0] w_tmr_val;
  logic             w_tmr_zero;

  // Hopper flags only matter here, and this choice is only used in SELECT.
  always_comb begin
    w_coin = NONE;
    if (int'(r_remaining) >= PENNY_F && !penny_empty) begin
      w_coin = PENNY;
    end else if (int'(r_remaining) >= HAP_F && !hap_empty) begin
      w_coin = HAP;
    end else if (int'(r_remaining) >= FARTH_F && !farth_empty) begin
      w_coin = FARTH;
    end
  end

  // Counts are loaded one short so the exit edge lands exactly N cycles later.
  always_comb begin
    w_tmr_load = 1'b0;
    w_tmr_val  = '0;
    if (r_state == SELECT) begin
      w_tmr_load = 1'b1;
      w_tmr_val  = CNT_W'(PULSE_CYC - 1);
    end else if (r_state == PULSE && w_tmr_zero) begin
      w_tmr_load = 1'b1;
      w_tmr_val  = CNT_W'(GAP_CYC - 1);
    end
  end

  pulse_timer #(
    .W (CNT_W)
  ) u_timer (
    .clk50m   (clk50m),
    .res      (res),
    .load     (w_tmr_load),
    .load_val (w_tmr_val),
    .zero     (w_tmr_zero)
  );

  always_ff @(posedge clk50m or negedge res) begin
    if (!res) begin
      r_state       <= IDLE;
      r_coin        <= NONE;
      r_remaining   <= '0;
      r_busy        <= 1'b0;
      r_done        <= 1'b0;
      r_fault       <= 1'b0;
      r_eject_penny <= 1'b0;
      r_eject_hap   <= 1'b0;
      r_eject_farth <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (req) begin
            r_remaining <= amount;
            r_fault     <= 1'b0;
            r_busy      <= 1'b1;
            r_state     <= SELECT;
          end
        end
        SELECT: begin
          if (r_remaining == '0) begin
            r_done  <= 1'b1;
            r_busy  <= 1'b0;
            r_state <= DONE;
          end else if (w_coin == NONE) begin
            r_fault <= 1'b1;
            r_busy  <= 1'b0;
            r_state <= FAULT;
          end else begin
            r_coin        <= w_coin;
            r_eject_penny <= (w_coin == PENNY);
            r_eject_hap   <= (w_coin == HAP);
            r_eject_farth <= (w_coin == FARTH);
            r_state       <= PULSE;
          end
        end
        PULSE: begin
          if (w_tmr_zero) begin
            r_remaining   <= r_remaining - AMT_W'(coin_value(r_coin));
            r_eject_penny <= 1'b0;
            r_eject_hap   <= 1'b0;
            r_eject_farth <= 1'b0;
            r_state       <= GAP;
          end
        end
        GAP: begin
          if (w_tmr_zero) begin
            r_state <= SELECT;
          end
        end
        DONE:    r_state <= IDLE;
        FAULT:   r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end

  assign eject_penny = r_eject_penny;
  assign eject_hap   = r_eject_hap;
  assign eject_farth = r_eject_farth;
  assign busy        = r_busy;
  assign done        = r_done;
  assign fault       = r_fault;
  assign remaining   = r_remaining;

endmodule

// File: tb/tb_change_dispenser.sv
// Bench for change_dispenser: a timeline model of the payout, checked every
// cycle, plus directed scenarios with hand-computed literal expectations.
module tb_change_dispenser;

  localparam int AMT_W     = 4;
  localparam int PULSE_CYC = 5;
  localparam int GAP_CYC   = 3;
  localparam int PER_COIN  = PULSE_CYC + GAP_CYC + 1;

  logic             clk50m;
  logic             res;
  logic             req;
  logic [AMT_W-1:0] amount;
  logic             penny_empty;
  logic             hap_empty;
  logic             farth_empty;
  logic             eject_penny;
  logic             eject_hap;
  logic             eject_farth;
  logic             busy;
  logic             done;
  logic             fault;
  logic [AMT_W-1:0] remaining;

  int checks = 0;
  int errors = 0;

  change_dispenser #(
    .AMT_W     (AMT_W),
    .PULSE_CYC (PULSE_CYC),
    .GAP_CYC   (GAP_CYC)
  ) dut (
    .clk50m      (clk50m),
    .res         (res),
    .req         (req),
    .amount      (amount),
    .penny_empty (penny_empty),
    .hap_empty   (hap_empty),
    .farth_empty (farth_empty),
    .eject_penny (eject_penny),
    .eject_hap   (eject_hap),
    .eject_farth (eject_farth),
    .busy        (busy),
    .done        (done),
    .fault       (fault),
    .remaining   (remaining)
  );

  initial clk50m = 1'b0;
  always #10 clk50m = ~clk50m;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // k-th coin of a greedy payout: value, 0 when fully paid, -1 when stuck.
  function automatic int coin_at(input int amt, input bit pe, input bit he, input bit fe, input int k);
    int rem;
    int c;
    rem = amt;
    for (int i = 0; i <= k; i++) begin
      if (rem == 0) return 0;
      if (rem >= 4 && !pe) c = 4;
      else if (rem >= 2 && !he) c = 2;
      else if (!fe) c = 1;
      else return -1;
      if (i == k) return c;
      rem -= c;
    end
    return 0;
  endfunction

  function automatic int plan_len(input int amt, input bit pe, input bit he, input bit fe, output bit f);
    int c;
    f = 1'b0;
    for (int k = 0; k < 16; k++) begin
      c = coin_at(amt, pe, he, fe, k);
      if (c <= 0) begin
        f = (c < 0);
        return k;
      end
    end
    return 16;
  endfunction

  // Model: a transaction is its acceptance cycle plus the captured request.
  int cyc = 0;
  int m_acc = 0;
  int m_amt = 0;
  bit m_have = 1'b0;
  bit m_pe, m_he, m_fe;

  function automatic bit model_idle();
    bit f;
    int n;
    if (!m_have) return 1'b1;
    n = plan_len(m_amt, m_pe, m_he, m_fe, f);
    return (cyc - m_acc) >= (1 + n * PER_COIN + 1);
  endfunction

  always @(posedge clk50m or negedge res) begin
    if (!res) begin
      m_have <= 1'b0;
    end else begin
      cyc <= cyc + 1;
      if (req && model_idle()) begin
        m_have <= 1'b1;
        m_acc  <= cyc + 1;
        m_amt  <= int'(amount);
        m_pe   <= penny_empty;
        m_he   <= hap_empty;
        m_fe   <= farth_empty;
      end
    end
  end

  always @(negedge clk50m) begin
    int t, n, end_t, s, c, e_rem;
    bit f;
    logic [2:0] e_ej;
    logic e_busy, e_done, e_fault;
    e_ej = 3'b000; e_busy = 1'b0; e_done = 1'b0; e_fault = 1'b0; e_rem = 0;
    if (m_have) begin
      t = cyc - m_acc;
      n = plan_len(m_amt, m_pe, m_he, m_fe, f);
      end_t = 1 + n * PER_COIN;
      e_rem = m_amt;
      for (int k = 0; k < n; k++) begin
        s = 1 + k * PER_COIN;
        c = coin_at(m_amt, m_pe, m_he, m_fe, k);
        if (t >= s && t < s + PULSE_CYC)
          e_ej = (c == 4) ? 3'b100 : (c == 2) ? 3'b010 : 3'b001;
        if (t >= s + PULSE_CYC) e_rem -= c;
      end
      e_busy  = (t < end_t);
      e_done  = (t == end_t) && !f;
      e_fault = f && (t >= end_t);
    end
    check("cmp_eject", {29'd0, eject_penny, eject_hap, eject_farth}, {29'd0, e_ej});
    check("cmp_busy", {31'd0, busy}, {31'd0, e_busy});
    check("cmp_done", {31'd0, done}, {31'd0, e_done});
    check("cmp_fault", {31'd0, fault}, {31'd0, e_fault});
    check("cmp_remaining", {28'd0, remaining}, e_rem);
  end

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk50m);
  endtask

  // Returns at the negedge right after the accepting edge (t = 0).
  task automatic request(input int a);
    @(negedge clk50m);
    req = 1'b1;
    amount = AMT_W'(a);
    @(negedge clk50m);
    req = 1'b0;
  endtask

  initial begin
    #1000000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

  initial begin
    res = 1'b0; req = 1'b0; amount = '0;
    penny_empty = 1'b0; hap_empty = 1'b0; farth_empty = 1'b0;
    wait_cyc(3);
    check("reset_busy", {31'd0, busy}, 0);
    check("reset_remaining", {28'd0, remaining}, 0);
    res = 1'b1;
    wait_cyc(2);

    // 7 with all hoppers full: penny, ha'penny, farthing.
    request(7);
    $display("txn amount=7 all full");
    wait_cyc(1);  check("t1_penny_on", {31'd0, eject_penny}, 1);
    wait_cyc(5);  check("t1_rem_after_penny", {28'd0, remaining}, 3);
    wait_cyc(4);  check("t1_hap_on", {31'd0, eject_hap}, 1);
    wait_cyc(5);  check("t1_rem_after_hap", {28'd0, remaining}, 1);
    wait_cyc(4);  check("t1_farth_on", {31'd0, eject_farth}, 1);
    wait_cyc(5);  check("t1_rem_after_farth", {28'd0, remaining}, 0);
    wait_cyc(4);  check("t1_done", {31'd0, done}, 1);
    wait_cyc(1);  check("t1_done_single", {31'd0, done}, 0);
    wait_cyc(2);

    // 4 with penny hopper empty: two ha'pennies.
    penny_empty = 1'b1;
    request(4);
    $display("txn amount=4 penny_empty");
    wait_cyc(1);  check("t2_hap_on", {31'd0, eject_hap}, 1);
    check("t2_no_penny", {31'd0, eject_penny}, 0);
    wait_cyc(5);  check("t2_rem_mid", {28'd0, remaining}, 2);
    wait_cyc(9);  check("t2_rem_end", {28'd0, remaining}, 0);
    wait_cyc(4);  check("t2_done", {31'd0, done}, 1);
    wait_cyc(2);
    penny_empty = 1'b0;

    // 3 with farthing hopper empty: one ha'penny, then fault with 1 unpaid.
    farth_empty = 1'b1;
    request(3);
    $display("txn amount=3 farth_empty");
    wait_cyc(10);
    check("t3_fault", {31'd0, fault}, 1);
    check("t3_rem_unpaid", {28'd0, remaining}, 1);
    check("t3_busy_low", {31'd0, busy}, 0);
    check("t3_no_done", {31'd0, done}, 0);
    wait_cyc(2);
    request(0);
    $display("txn amount=0 after fault");
    check("t3_fault_cleared", {31'd0, fault}, 0);
    wait_cyc(1);  check("t3_done_after_clear", {31'd0, done}, 1);
    wait_cyc(2);
    farth_empty = 1'b0;

    // Zero amount: done one edge after SELECT, busy for a single cycle.
    request(0);
    $display("txn amount=0");
    check("t4_busy_one", {31'd0, busy}, 1);
    wait_cyc(1);
    check("t4_done", {31'd0, done}, 1);
    check("t4_busy_drop", {31'd0, busy}, 0);
    wait_cyc(2);

    // 6, with a 15 request arriving during the first pulse (ignored).
    request(6);
    $display("txn amount=6 with ignored req amount=15");
    wait_cyc(2);
    request(15);
    check("t5_penny_still", {31'd0, eject_penny}, 1);
    wait_cyc(15);
    check("t5_done", {31'd0, done}, 1);
    check("t5_rem_zero", {28'd0, remaining}, 0);
    wait_cyc(3);

    // Reset in the middle of a penny pulse.
    request(7);
    $display("txn amount=7 reset mid-pulse");
    wait_cyc(3);
    check("t6_penny_before_reset", {31'd0, eject_penny}, 1);
    #2 res = 1'b0;
    #1;
    check("t6_penny_dropped", {31'd0, eject_penny}, 0);
    check("t6_busy_dropped", {31'd0, busy}, 0);
    check("t6_rem_cleared", {28'd0, remaining}, 0);
    wait_cyc(2);
    res = 1'b1;
    wait_cyc(20);
    check("t6_idle_after", {31'd0, busy}, 0);
    check("t6_no_eject", {29'd0, eject_penny, eject_hap, eject_farth}, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
